nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nsa_pkg.sv | 12 +
 rtl/nibble_csa_slice.sv | 28 ++
 rtl/nibble_serial_adder.sv | 108 ++++++++++
 tb/tb_nibble_serial_adder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared state encoding and nibble width for the nibble serial adder
package nsa_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_e;

endpackage

// File: rtl/nibble_csa_slice.sv
// rtl/nibble_csa_slice.sv - 4-bit carry-select adder slice, also exposes carry into bit 3
module nibble_csa_slice
    import nsa_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout,
    output logic             c3
);

    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;
    logic       sel;

    // Low pair ripples from cin; the high pair is precomputed for both carries and selected.
    assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    assign sel = lo[2];

    assign sum  = sel ? {hi1[1:0], lo[1:0]} : {hi0[1:0], lo[1:0]};
    assign cout = sel ? hi1[2] : hi0[2];
    assign c3   = sel ? (a[2] | b[2]) : (a[2] & b[2]);

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder computing one nibble per clock through a single slice
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int              IDX_W    = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    nsa_state_e       state, state_n;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last;

    logic [NIB_W-1:0] s_a, s_b, s_sum;
    logic             s_cout, s_c3;

    assign s_a = a_q[idx*NIB_W +: NIB_W];
    assign s_b = b_q[idx*NIB_W +: NIB_W];

    nibble_csa_slice u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout),
        .c3   (s_c3)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    last    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Result registers only change in RUN, so they hold steady through DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
        end else if (state == RUN) begin
            sum[idx*NIB_W +: NIB_W] <= s_sum;
            carry_q                 <= s_cout;
            if (last) begin
                idx  <= '0;
                cout <= s_cout;
                ovf  <= s_c3 ^ s_cout;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for the nibble serial adder
module tb_nibble_serial_adder;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   ov_prev = 1'b0;
    exp_t exp_q[$];
    int   lat_q[$];

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && in_ready)
                chk("ready_valid_exclusive", 32'(in_ready), 32'd0);
            if (out_valid && !ov_prev) begin
                if (lat_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    int t;
                    t = lat_q.pop_front();
                    chk("latency", 32'(cyc - t), 32'd4);
                end
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sum",  32'(sum),  32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
                chk("ovf",  32'(ovf),  32'(e.v));
            end
            ov_prev = out_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                         input logic [15:0] es, input logic ec, input logic ev, input bit wiggle);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        a = ai; b = bi; cin = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back('{es, ec, ev});
        lat_q.push_back(cyc);
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        if (wiggle) begin
            repeat (3) begin
                @(posedge clk); #1;
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic rnd_op();
        logic [15:0] ra, rb, rs;
        logic        rc, co, v;
        logic [16:0] full;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
        rs = full[15:0];
        co = full[16];
        v  = (ra[15] == rb[15]) && (rs[15] != ra[15]);
        do_op(ra, rb, rc, rs, co, v, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);

        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        do_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b1);
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        do_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_op(16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        drain();

        // Held result with the consumer stalled
        out_ready = 1'b0;
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_sum",       32'(sum),       32'h8000);
            chk("hold_in_ready",  32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_drain_in_ready",  32'(in_ready),  32'd1);
        chk("post_drain_out_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of RUN, with idx at 2
        do_op(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrun_rst_in_ready",  32'(in_ready),  32'd1);
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_sum",       32'(sum),       32'd0);
        exp_q.delete();
        lat_q.delete();
        reset = 1'b0;
        do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 1000; i++) rnd_op();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
